// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard-detection unit for a classic 5-stage pipeline.
// Produces ALU operand bypass selects, load-use / RAW stall control,
// branch flush control and a saturating stall-cycle counter.
module forward_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_memread,
    input  logic              branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Remaining stall cycles loaded when a multi-cycle load-use stall begins.
    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A writer only matches a real, nonzero destination; r0 is hard-wired zero.
    function automatic logic wr_match(input logic              we,
                                      input logic [ADDR_W-1:0] rd,
                                      input logic [ADDR_W-1:0] src);
        return we && (rd != {ADDR_W{1'b0}}) && (rd == src);
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_a_s, fwd_b_s;
    logic       hazard_s;
    logic       pc_write_s, ifid_write_s, idex_bubble_s, ifid_flush_s;

    // Operand bypass selects: MEM result is younger, so it wins over WB.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (FWD_EN != 0) begin
            if (wr_match(mem_regwrite, mem_rd, ex_rs)) begin
                fwd_a_s = 2'b10;
            end else if (wr_match(wb_regwrite, wb_rd, ex_rs)) begin
                fwd_a_s = 2'b01;
            end else begin
                fwd_a_s = 2'b00;
            end
            if (wr_match(mem_regwrite, mem_rd, ex_rt)) begin
                fwd_b_s = 2'b10;
            end else if (wr_match(wb_regwrite, wb_rd, ex_rt)) begin
                fwd_b_s = 2'b01;
            end else begin
                fwd_b_s = 2'b00;
            end
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end
    end

    // Hazard detect: only loads stall when bypassing exists; otherwise any
    // in-flight EX/MEM producer of an ID source must be waited out.
    always_comb begin
        hazard_s = 1'b0;
        if (FWD_EN != 0) begin
            hazard_s = id_valid && ex_memread &&
                       (wr_match(ex_regwrite, ex_rd, id_rs) ||
                        wr_match(ex_regwrite, ex_rd, id_rt));
        end else begin
            hazard_s = id_valid &&
                       (wr_match(ex_regwrite,  ex_rd,  id_rs) ||
                        wr_match(ex_regwrite,  ex_rd,  id_rt) ||
                        wr_match(mem_regwrite, mem_rd, id_rs) ||
                        wr_match(mem_regwrite, mem_rd, id_rt));
        end
    end

    // Stall FSM next-state and pipeline control; branch overrides any stall,
    // and an asserted reset forces the quiescent control values.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        idex_bubble_s = 1'b0;
        ifid_flush_s  = 1'b0;
        if (!reset) begin
            state_d = RUN;
            rem_d   = 3'd0;
        end else if (branch_taken) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            state_d       = RUN;
            rem_d         = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                        if ((LOAD_STALL > 1) && (FWD_EN != 0)) begin
                            state_d = STALL;
                            rem_d   = REM_INIT;
                        end else begin
                            state_d = RUN;
                            rem_d   = 3'd0;
                        end
                    end else begin
                        state_d = RUN;
                        rem_d   = 3'd0;
                    end
                end
                STALL: begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_bubble_s = 1'b1;
                    if (rem_q <= 3'd1) begin
                        state_d = RUN;
                        rem_d   = 3'd0;
                    end else begin
                        state_d = STALL;
                        rem_d   = rem_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 3'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, remaining-stall and counter registers; reset clears them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            rem_q       <= 3'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign forward_a    = fwd_a_s;
    assign forward_b    = fwd_b_s;
    assign pc_write     = pc_write_s;
    assign ifid_write   = ifid_write_s;
    assign idex_bubble  = idex_bubble_s;
    assign ifid_flush   = ifid_flush_s;
    assign stall_active = (state_q == STALL);
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench: dut_a is the load-use configuration (LOAD_STALL=3,
// CNT_W=4), dut_b the stall-only configuration (FWD_EN=0).
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, ex_regwrite, mem_regwrite, wb_regwrite, ex_memread, branch_taken;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic       a_pcw, a_ifw, a_bub, a_fl, a_act;
    logic       b_pcw, b_ifw, b_bub, b_fl, b_act;
    logic [3:0]  a_cnt;
    logic [15:0] b_cnt;

    typedef struct {
        string       tag;
        bit          on_b;
        logic [1:0]  fa, fb;
        logic        pcw, ifw, bub, fl, act;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.ADDR_W(5), .LOAD_STALL(3), .FWD_EN(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .branch_taken(branch_taken),
        .forward_a(a_fa), .forward_b(a_fb), .pc_write(a_pcw), .ifid_write(a_ifw),
        .idex_bubble(a_bub), .ifid_flush(a_fl), .stall_active(a_act), .stall_cnt(a_cnt));

    forward_hazard_unit #(.ADDR_W(5), .LOAD_STALL(1), .FWD_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .branch_taken(branch_taken),
        .forward_a(b_fa), .forward_b(b_fb), .pc_write(b_pcw), .ifid_write(b_ifw),
        .idex_bubble(b_bub), .ifid_flush(b_fl), .stall_active(b_act), .stall_cnt(b_cnt));

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
        end
    endtask

    // Scoreboard push: expected output values for the current step.
    task automatic expect_out(input string tag, input bit on_b, input logic [1:0] fa, input logic [1:0] fb,
                              input logic pcw, input logic ifw, input logic bub, input logic fl,
                              input logic act, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.on_b = on_b; e.fa = fa; e.fb = fb; e.pcw = pcw; e.ifw = ifw;
        e.bub = bub; e.fl = fl; e.act = act; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Scoreboard pop: compare every queued expectation against the DUT now.
    task automatic compare_all();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.on_b) begin
                chk(e.tag, "fa", {14'd0, b_fa}, {14'd0, e.fa});
                chk(e.tag, "fb", {14'd0, b_fb}, {14'd0, e.fb});
                chk(e.tag, "pcw", {15'd0, b_pcw}, {15'd0, e.pcw});
                chk(e.tag, "ifw", {15'd0, b_ifw}, {15'd0, e.ifw});
                chk(e.tag, "bub", {15'd0, b_bub}, {15'd0, e.bub});
                chk(e.tag, "flush", {15'd0, b_fl}, {15'd0, e.fl});
                chk(e.tag, "act", {15'd0, b_act}, {15'd0, e.act});
                chk(e.tag, "cnt", b_cnt, e.cnt);
            end else begin
                chk(e.tag, "fa", {14'd0, a_fa}, {14'd0, e.fa});
                chk(e.tag, "fb", {14'd0, a_fb}, {14'd0, e.fb});
                chk(e.tag, "pcw", {15'd0, a_pcw}, {15'd0, e.pcw});
                chk(e.tag, "ifw", {15'd0, a_ifw}, {15'd0, e.ifw});
                chk(e.tag, "bub", {15'd0, a_bub}, {15'd0, e.bub});
                chk(e.tag, "flush", {15'd0, a_fl}, {15'd0, e.fl});
                chk(e.tag, "act", {15'd0, a_act}, {15'd0, e.act});
                chk(e.tag, "cnt", {12'd0, a_cnt}, e.cnt);
            end
        end
    endtask

    // Compare at the falling edge, then move to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 1'b0; ex_regwrite = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        ex_memread = 1'b0; branch_taken = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    endtask

    task automatic load_use_r5();
        clear_in();
        id_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    endtask

    initial begin
        clear_in();
        reset = 1'b0;
        // Reset held: a hazard and a branch must not disturb the default controls.
        load_use_r5();
        branch_taken = 1'b1;
        expect_out("rst_hold", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();
        clear_in();
        reset = 1'b1;

        // Forwarding priority: MEM over WB, then WB alone.
        mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1; ex_rs = 5'd3;
        expect_out("fwd_mem", 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        expect_out("fwd_off", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();
        mem_regwrite = 1'b0;
        expect_out("fwd_wb", 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();
        mem_regwrite = 1'b1; ex_rt = 5'd4; wb_rd = 5'd4;
        expect_out("fwd_ab", 1'b0, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();

        // Register 0 never forwards, and a load into r0 never stalls.
        clear_in();
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        id_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1;
        expect_out("zero_reg", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();
        load_use_r5();
        id_valid = 1'b0;
        expect_out("no_valid", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();

        // Load-use stall, LOAD_STALL=3: three held cycles, STALL on the last two.
        load_use_r5();
        expect_out("lu_c1", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cycle();
        clear_in();
        mem_rd = 5'd5; mem_regwrite = 1'b1;
        expect_out("lu_c2", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1);
        cycle();
        expect_out("lu_c3", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
        cycle();
        clear_in();
        expect_out("lu_done", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
        cycle();

        // Branch in stall cycle 2 aborts the stall.
        load_use_r5();
        expect_out("br_c1", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
        cycle();
        clear_in();
        branch_taken = 1'b1;
        expect_out("br_c2", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd4);
        cycle();
        clear_in();
        expect_out("br_after", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
        cycle();
        load_use_r5();
        branch_taken = 1'b1;
        expect_out("br_run_hz", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4);
        cycle();
        clear_in();
        expect_out("br_run_nx", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
        cycle();

        // Asynchronous reset in the middle of a STALL.
        load_use_r5();
        expect_out("rs_c1", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
        cycle();
        clear_in();
        #2;
        expect_out("rs_stall", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd5);
        compare_all();
        reset = 1'b0;
        #1;
        expect_out("rs_async", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        expect_out("rs_rel1", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();
        expect_out("rs_rel2", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        cycle();

        // Saturation: 20 held cycles on a 4-bit counter, then one trailing stall.
        load_use_r5();
        for (int i = 0; i < 20; i++) begin
            cycle();
        end
        clear_in();
        expect_out("sat_tail", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd15);
        cycle();
        expect_out("sat_hold", 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd15);
        cycle();

        // Stall-only mode: r7 producer stalls while in EX and in MEM, never forwards.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        clear_in();
        id_valid = 1'b1; id_rt = 5'd7; ex_regwrite = 1'b1; ex_rd = 5'd7; ex_rs = 5'd7; ex_rt = 5'd7;
        expect_out("so_ex", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cycle();
        ex_regwrite = 1'b0; mem_rd = 5'd7; mem_regwrite = 1'b1;
        expect_out("so_mem", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
        cycle();
        mem_regwrite = 1'b0; wb_rd = 5'd7; wb_regwrite = 1'b1;
        expect_out("so_wb", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
